dwa_rotate_ctrl: RTL and testbench
==================================

// Module: dwa_rotate_ctrl
// PURPOSE
//  Data-weighted-averaging (DWA) rotation controller for the unit-element DAC of the SAR/pipeline stage.
//  Converts each accepted sample code into a thermometer word, then rotates it by a running pointer
//  through one barrelshift_single instance. The pointer then advances by the code, modulo N_WORD.
//  Sits between the quantiser code path and the DAC element-select register, with valid/ready on both sides.
// PARAMETERS
//  BIT_SHIFT  3               pointer / shift-amount width
//  N_WORD     2**BIT_SHIFT    number of unit elements (word width)
// PORTS
//  clk        in   1            single clock, all state on rising edge
//  rst        in   1            synchronous, active-high reset
//  en         in   1            controller enable
//  mode       in   2            0=DWA, 1=FREEZE (ptr held), 2=SWEEP (ptr += 1 per sample), 3=reserved (treated as FREEZE)
//  ptr_load   in   1            one-cycle pulse: load ptr_init into pointer
//  ptr_init   in   BIT_SHIFT    pointer load value
//  in_valid   in   1            sample code valid
//  in_ready   out  1            controller can accept a code
//  code       in   BIT_SHIFT+1  number of elements to enable, 0..N_WORD
//  out_valid  out  1            sel valid
//  out_ready  in   1            downstream accepts sel
//  sel        out  N_WORD       rotated thermometer element select
//  ptr        out  BIT_SHIFT    current pointer (pre-update value of the next sample)
//  wrap       out  1            registered with sel: this sample's pointer update crossed N_WORD
//  code_ovf   out  1            sticky: a code > N_WORD was accepted; cleared only by rst
// BEHAVIOUR
//  Reset values: ptr=0, sel=0, out_valid=0, wrap=0, code_ovf=0, state=IDLE; in_ready=0 while state!=RUN.
//  FSM states and transitions:
//  - IDLE:  en=1 -> RUN.
//  - RUN:   en=0 and out_valid=0 -> IDLE; en=0 and out_valid=1 -> FLUSH.
//  - FLUSH: no accepts; out_valid&out_ready -> IDLE, or -> RUN if en=1 again.
//  Accept: in_valid & in_ready, with in_ready = (state==RUN) & (!out_valid | out_ready). Full throughput, no bubbles.
//  Latency: 1 cycle. On the accept edge, sel, wrap and out_valid are registered.
//  out_valid/sel/wrap hold stable while out_valid & !out_ready.
//  Datapath per accepted code c:
//  - cc = min(c, N_WORD); c > N_WORD sets code_ovf.
//  - therm = (1<<cc)-1, i.e. all ones when cc=N_WORD.
//  - sel = rotate-left(therm, ptr).
//  Pointer update on accept, by mode:
//  - DWA:    s = ptr + cc (BIT_SHIFT+1 bits); ptr <= s[BIT_SHIFT-1:0]; wrap <= s[BIT_SHIFT].
//            cc=N_WORD leaves ptr unchanged and sets wrap=1.
//  - SWEEP:  ptr <= ptr+1 mod N_WORD; wrap <= (ptr==N_WORD-1).
//  - FREEZE: ptr unchanged; wrap <= 0.
//  The mode is sampled on the accept cycle.
//  ptr_load: ptr <= ptr_init next edge in any state, with priority over the accept update.
//  A sample accepted in the same cycle still uses the old ptr for its sel.
//  Reset mid-operation: pending output is discarded (out_valid=0 next edge) and ptr returns to 0.
//  No X propagation: sel is only updated on accept.
// STRUCTURE
//  dwa_pkg: mode_e {MODE_DWA, MODE_FREEZE, MODE_SWEEP, MODE_RSVD}; state_e {ST_IDLE, ST_RUN, ST_FLUSH}.
//  Sub-module: one barrelshift_single #(.bit_shift(BIT_SHIFT)) rotates the thermometer word combinationally.
//  The controller owns the FSM, pointer register, output register and handshake.
// TESTING
//  1 DWA, N_WORD=8, ptr=0, codes 3,4,2 back-to-back with out_ready=1 -> sel 8'h07, 8'h78, 8'h81;
//    ptr 3,7,1; wrap 0,0,1.
//  2 Backpressure: out_ready=0 for 3 cycles after first accept -> in_ready=0, sel/ptr held;
//    release -> next code is accepted in the same cycle.
//  3 ptr_load with ptr_init=5 in the same cycle as accepting code 2 at ptr=1 -> sel=8'h06; ptr=5 next cycle.
//  4 code=8 at ptr=6 -> sel=8'hFF, ptr=6, wrap=1.
//    code=9 -> clamped like 8, code_ovf=1 and stays set.
//  5 SWEEP with code=1 x9 from ptr=0 -> sel 01,02,..,80,01; wrap pulses on the 8th sample.
//  6 en drop while out_valid=1 and out_ready=0 -> FLUSH, no accepts; out_ready -> IDLE.
//    rst mid-stream -> all outputs at reset values next edge.

Source files
------------

// File: rtl/dwa_pkg.sv
// ============================================================================
// Module      : dwa_pkg
// Description : Shared types for the DWA rotation controller (modes, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dwa_pkg;

    localparam int C_DEFAULT_BIT_SHIFT = 3;

    typedef enum logic [1:0] {
        MODE_DWA    = 2'd0,
        MODE_FREEZE = 2'd1,
        MODE_SWEEP  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/barrelshift_single.sv
// ============================================================================
// Module      : barrelshift_single
// Description : Combinational log-stage rotate-left of a 2**bit_shift word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrelshift_single #(
    parameter int bit_shift = 3
) (
    input  logic [2**bit_shift-1:0] i_data,
    input  logic [bit_shift-1:0]    i_shamt,
    output logic [2**bit_shift-1:0] o_data
);

    localparam int c_width = 2**bit_shift;

    logic [c_width-1:0] w_stage [0:bit_shift];

    assign w_stage[0] = i_data;

    // Stage k rotates by 2**k, which is always strictly less than the word width.
    generate
        for (genvar k = 0; k < bit_shift; k++) begin : g_stage
            localparam int c_amt = 2**k;
            assign w_stage[k+1] = i_shamt[k]
                ? {w_stage[k][c_width-1-c_amt:0], w_stage[k][c_width-1:c_width-c_amt]}
                : w_stage[k];
        end
    endgenerate

    assign o_data = w_stage[bit_shift];

endmodule

`default_nettype wire

// File: rtl/dwa_rotate_ctrl.sv
// ============================================================================
// Module      : dwa_rotate_ctrl
// Description : DWA rotation controller: thermometer-encodes each accepted code,
//               rotates it by a running pointer and advances the pointer by mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dwa_rotate_ctrl
    import dwa_pkg::*;
#(
    parameter int BIT_SHIFT = C_DEFAULT_BIT_SHIFT,
    parameter int N_WORD    = 2**BIT_SHIFT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic                 ptr_load,
    input  logic [BIT_SHIFT-1:0] ptr_init,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_SHIFT:0]   code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_WORD-1:0]    sel,
    output logic [BIT_SHIFT-1:0] ptr,
    output logic                 wrap,
    output logic                 code_ovf
);

    localparam logic [BIT_SHIFT:0]   c_n_word  = (BIT_SHIFT+1)'(N_WORD);
    localparam logic [N_WORD-1:0]    c_one     = N_WORD'(1);
    localparam logic [BIT_SHIFT-1:0] c_ptr_max = {BIT_SHIFT{1'b1}};
    localparam logic [BIT_SHIFT-1:0] c_ptr_one = BIT_SHIFT'(1);

    state_e               r_state;
    logic                 r_out_valid;
    logic                 r_wrap;
    logic                 r_code_ovf;
    logic [N_WORD-1:0]    r_sel;
    logic [BIT_SHIFT-1:0] r_ptr;

    mode_e                w_mode;
    logic                 w_accept;
    logic                 w_code_big;
    logic [BIT_SHIFT:0]   w_cc;
    logic [BIT_SHIFT:0]   w_sum;
    logic [N_WORD-1:0]    w_one_sh;
    logic [N_WORD-1:0]    w_therm;
    logic [N_WORD-1:0]    w_rot;
    logic [BIT_SHIFT-1:0] w_ptr_next;
    logic                 w_wrap_next;

    assign w_mode     = mode_e'(mode);
    assign in_ready   = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_code_big = (code > c_n_word);
    assign w_cc       = w_code_big ? c_n_word : code;

    // Shifting a one past the MSB yields zero, so cc=N_WORD wraps to all ones.
    assign w_one_sh = c_one << w_cc;
    assign w_therm  = w_one_sh - c_one;

    barrelshift_single #(
        .bit_shift (BIT_SHIFT)
    ) u_rot (
        .i_data  (w_therm),
        .i_shamt (r_ptr),
        .o_data  (w_rot)
    );

    always_comb begin
        w_ptr_next  = r_ptr;
        w_wrap_next = 1'b0;
        w_sum       = {1'b0, r_ptr} + w_cc;
        case (w_mode)
            MODE_DWA: begin
                w_ptr_next  = w_sum[BIT_SHIFT-1:0];
                w_wrap_next = w_sum[BIT_SHIFT];
            end
            MODE_SWEEP: begin
                w_ptr_next  = r_ptr + c_ptr_one;
                w_wrap_next = (r_ptr == c_ptr_max);
            end
            default: begin
                w_ptr_next  = r_ptr;
                w_wrap_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_sel       <= '0;
            r_wrap      <= 1'b0;
            r_ptr       <= '0;
            r_code_ovf  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!en) r_state <= r_out_valid ? ST_FLUSH : ST_IDLE;
                end
                ST_FLUSH: begin
                    if (r_out_valid && out_ready) r_state <= en ? ST_RUN : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_sel       <= w_rot;
                r_wrap      <= w_wrap_next;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            // A load wins over the accept update; the accepted sample already used the old pointer.
            if (ptr_load) begin
                r_ptr <= ptr_init;
            end else if (w_accept) begin
                r_ptr <= w_ptr_next;
            end

            if (w_accept && w_code_big) r_code_ovf <= 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign sel       = r_sel;
    assign wrap      = r_wrap;
    assign ptr       = r_ptr;
    assign code_ovf  = r_code_ovf;

endmodule

`default_nettype wire

// File: tb/tb_dwa_rotate_ctrl.sv
// ============================================================================
// Module      : tb_dwa_rotate_ctrl
// Description : Scoreboard bench for dwa_rotate_ctrl with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dwa_rotate_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       ptr_load;
    logic [2:0] ptr_init;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sel;
    logic [2:0] ptr;
    logic       wrap;
    logic       code_ovf;

    dwa_rotate_ctrl #(.BIT_SHIFT(3), .N_WORD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .ptr_load  (ptr_load),
        .ptr_init  (ptr_init),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code      (code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .ptr       (ptr),
        .wrap      (wrap),
        .code_ovf  (code_ovf)
    );

    typedef struct {
        logic [7:0] sel;
        logic       wrap;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Model state: 0=idle, 1=run, 2=flush
    int   m_st  = 0;
    int   m_ptr = 0;
    bit   m_ov  = 0;
    bit   m_ovf = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_sel(input int p, input int cc);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < cc; i++) s[(p + i) % 8] = 1'b1;
        return s;
    endfunction

    // One clock of stimulus plus the model's view of that clock.
    task automatic cycle(input bit t_rst, input bit t_en, input int t_mode, input bit t_ld,
                         input int t_init, input bit t_iv, input int t_code, input bit t_ordy);
        bit   exp_ready;
        bit   acc;
        int   cc;
        int   n_st;
        exp_t e;
        @(posedge clk);
        #1;
        rst       = t_rst;
        en        = t_en;
        mode      = 2'(t_mode);
        ptr_load  = t_ld;
        ptr_init  = 3'(t_init);
        in_valid  = t_iv;
        code      = 4'(t_code);
        out_ready = t_ordy;

        exp_ready = (m_st == 1) && (!m_ov || t_ordy);
        acc       = t_iv && exp_ready && !t_rst;
        cc        = (t_code > 8) ? 8 : t_code;
        if (acc) begin
            e.sel = ref_sel(m_ptr, cc);
            if (t_mode == 0)      e.wrap = (m_ptr + cc >= 8);
            else if (t_mode == 2) e.wrap = (m_ptr == 7);
            else                  e.wrap = 1'b0;
            q.push_back(e);
        end

        @(negedge clk);
        check("in_ready", in_ready, exp_ready);
        check("ptr", ptr, m_ptr);
        check("out_valid", out_valid, m_ov);
        check("code_ovf", code_ovf, m_ovf);

        if (t_rst) begin
            m_st = 0; m_ptr = 0; m_ov = 0; m_ovf = 0;
            q.delete();
        end else begin
            n_st = m_st;
            if (m_st == 0 && t_en) n_st = 1;
            else if (m_st == 1 && !t_en) n_st = m_ov ? 2 : 0;
            else if (m_st == 2 && m_ov && t_ordy) n_st = t_en ? 1 : 0;
            if (t_ld) m_ptr = t_init;
            else if (acc && t_mode == 0) m_ptr = (m_ptr + cc) % 8;
            else if (acc && t_mode == 2) m_ptr = (m_ptr + 1) % 8;
            if (acc) m_ov = 1;
            else if (t_ordy) m_ov = 0;
            if (acc && t_code > 8) m_ovf = 1;
            m_st = n_st;
        end
    endtask

    // Monitor: whatever the DUT presents must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got out_valid=1 expected no pending sample at %0t", $time);
            end else begin
                check("sel", sel, q[0].sel);
                check("wrap", wrap, q[0].wrap);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd0; ptr_load = 1'b0; ptr_init = 3'd0;
        in_valid = 1'b0; code = 4'd0; out_ready = 1'b0;

        repeat (2) cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 1);
        // DWA back-to-back 3,4,2
        cycle(0, 1, 0, 0, 0, 1, 3, 1);
        cycle(0, 1, 0, 0, 0, 1, 4, 1);
        cycle(0, 1, 0, 0, 0, 1, 2, 1);
        cycle(0, 1, 0, 0, 0, 0, 0, 1);
        // Backpressure
        cycle(0, 1, 0, 0, 0, 1, 1, 1);
        repeat (3) cycle(0, 1, 0, 0, 0, 1, 5, 0);
        cycle(0, 1, 0, 0, 0, 1, 5, 1);
        cycle(0, 1, 0, 0, 0, 0, 0, 1);
        // Load collides with an accept at ptr=1
        cycle(0, 1, 0, 1, 1, 0, 0, 1);
        cycle(0, 1, 0, 1, 5, 1, 2, 1);
        cycle(0, 1, 0, 0, 0, 0, 0, 1);
        // Full-scale and overflowing codes at ptr=6
        cycle(0, 1, 0, 1, 6, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 1, 8, 1);
        cycle(0, 1, 0, 0, 0, 1, 9, 1);
        cycle(0, 1, 0, 0, 0, 0, 0, 1);
        // Sweep from 0
        cycle(0, 1, 2, 1, 0, 0, 0, 1);
        repeat (9) cycle(0, 1, 2, 0, 0, 1, 1, 1);
        cycle(0, 1, 2, 0, 0, 0, 0, 1);
        // Enable drop under backpressure, flush, then reset mid-stream
        cycle(0, 1, 0, 0, 0, 1, 3, 0);
        cycle(0, 0, 0, 0, 0, 1, 2, 0);
        cycle(0, 0, 0, 0, 0, 1, 2, 0);
        cycle(0, 0, 0, 0, 0, 1, 2, 1);
        cycle(0, 1, 0, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 1, 4, 0);
        cycle(0, 1, 0, 0, 0, 1, 4, 0);
        cycle(1, 1, 0, 0, 0, 1, 4, 1);
        cycle(0, 1, 0, 0, 0, 0, 0, 1);

        for (int n = 0; n < 2500; n++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 15) != 0),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 19) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8)),
                  ($urandom_range(0, 3) != 0));
        end
        cycle(0, 1, 0, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
